// File: rtl/ultrasonic_ping_scheduler.sv
// Round-robin ping/measure engine shared by N ultrasonic rangefinders.
// Each sensor owns one fixed-length slot: trigger pulse, wait for the echo,
// measure the echo width with a timeout, report it, then idle until the
// slot ends so that echoes from different sensors never overlap.
module ultrasonic_ping_scheduler #(
  parameter int unsigned N_SENSORS      = 4,
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned SLOT_CYCLES    = 3000000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned CNT_W          = 23,
  parameter int unsigned NEAR_THRESH    = 29000,
  localparam int unsigned IDX_W         = $clog2(N_SENSORS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trig,
  output logic                 dist_valid,
  output logic [IDX_W-1:0]     dist_sensor,
  output logic [CNT_W-1:0]     dist_count,
  output logic                 timeout,
  output logic [N_SENSORS-1:0] near,
  output logic                 buzz_en
);

  localparam int unsigned SLOT_W = $clog2(SLOT_CYCLES);

  localparam logic [SLOT_W-1:0] TRIG_LAST = SLOT_W'(TRIG_CYCLES - 1);
  localparam logic [SLOT_W-1:0] TO_LAST   = SLOT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  NEAR_TH   = CNT_W'(NEAR_THRESH);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_SENSORS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StReport,
    StHoldoff
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SLOT_W-1:0]    slot_cnt_q, slot_cnt_d;
  logic [CNT_W-1:0]     echo_cnt_q, echo_cnt_d;
  logic [N_SENSORS-1:0] echo_s1_q, echo_s2_q;
  logic [N_SENSORS-1:0] trig_q, trig_d;
  logic                 dist_valid_q, dist_valid_d;
  logic [IDX_W-1:0]     dist_sensor_q, dist_sensor_d;
  logic [CNT_W-1:0]     dist_count_q, dist_count_d;
  logic                 timeout_q, timeout_d;
  logic [N_SENSORS-1:0] near_q, near_d;
  logic                 buzz_en_q, buzz_en_d;

  logic echo_cur;

  // Only the synchronized echo of the sensor being served matters.
  assign echo_cur = echo_s2_q[idx_q];

  // Next-state and registered-output logic for the slot sequencer.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    slot_cnt_d    = slot_cnt_q;
    echo_cnt_d    = echo_cnt_q;
    dist_sensor_d = dist_sensor_q;
    dist_count_d  = dist_count_q;
    timeout_d     = timeout_q;
    near_d        = near_q;

    if (state_q != StIdle) begin
      slot_cnt_d = slot_cnt_q + SLOT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        slot_cnt_d = '0;
        if (en) begin
          state_d = StTrig;
        end
      end
      StTrig: begin
        if (slot_cnt_q == TRIG_LAST) begin
          state_d = StWaitRise;
        end
      end
      StWaitRise: begin
        // Timeout wins over a simultaneous echo edge.
        if (slot_cnt_q == TO_LAST) begin
          state_d      = StReport;
          dist_count_d = '1;
          timeout_d    = 1'b1;
        end else if (echo_cur) begin
          state_d    = StMeasure;
          echo_cnt_d = CNT_W'(1);
        end
      end
      StMeasure: begin
        if (slot_cnt_q == TO_LAST) begin
          state_d      = StReport;
          dist_count_d = '1;
          timeout_d    = 1'b1;
        end else if (echo_cur) begin
          // Saturate rather than wrap on very long echoes.
          if (echo_cnt_q != '1) begin
            echo_cnt_d = echo_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d      = StReport;
          dist_count_d = echo_cnt_q;
          timeout_d    = 1'b0;
        end
      end
      StReport: begin
        state_d       = StHoldoff;
        near_d[idx_q] = !timeout_q && (dist_count_q < NEAR_TH);
      end
      StHoldoff: begin
        if (slot_cnt_q == SLOT_LAST) begin
          slot_cnt_d = '0;
          idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          state_d    = en ? StTrig : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d == StReport) begin
      dist_sensor_d = idx_q;
    end
    dist_valid_d = (state_d == StReport);

    trig_d = '0;
    if (state_d == StTrig) begin
      trig_d[idx_d] = 1'b1;
    end

    buzz_en_d = |near_q;
  end

  // State, synchronizer and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      slot_cnt_q    <= '0;
      echo_cnt_q    <= '0;
      echo_s1_q     <= '0;
      echo_s2_q     <= '0;
      trig_q        <= '0;
      dist_valid_q  <= 1'b0;
      dist_sensor_q <= '0;
      dist_count_q  <= '0;
      timeout_q     <= 1'b0;
      near_q        <= '0;
      buzz_en_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      slot_cnt_q    <= slot_cnt_d;
      echo_cnt_q    <= echo_cnt_d;
      echo_s1_q     <= echo;
      echo_s2_q     <= echo_s1_q;
      trig_q        <= trig_d;
      dist_valid_q  <= dist_valid_d;
      dist_sensor_q <= dist_sensor_d;
      dist_count_q  <= dist_count_d;
      timeout_q     <= timeout_d;
      near_q        <= near_d;
      buzz_en_q     <= buzz_en_d;
    end
  end

  assign trig        = trig_q;
  assign dist_valid  = dist_valid_q;
  assign dist_sensor = dist_sensor_q;
  assign dist_count  = dist_count_q;
  assign timeout     = timeout_q;
  assign near        = near_q;
  assign buzz_en     = buzz_en_q;

endmodule

// File: tb/tb_ultrasonic_ping_scheduler.sv
// Scoreboard bench for ultrasonic_ping_scheduler: each slot's expected
// result is queued when its echo is scheduled and checked on dist_valid.
module tb_ultrasonic_ping_scheduler;

  localparam int N       = 4;
  localparam int TRIG_C  = 4;
  localparam int SLOT_C  = 200;
  localparam int TO_C    = 150;
  localparam int THRESH  = 50;
  localparam int CW      = 8;
  localparam int TO_LAST = TO_C - 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic [N-1:0]  echo  = '0;
  logic [N-1:0]  trig;
  logic          dist_valid;
  logic [1:0]    dist_sensor;
  logic [CW-1:0] dist_count;
  logic          timeout;
  logic [N-1:0]  near;
  logic          buzz_en;

  typedef struct packed {
    logic [1:0]    s;
    logic [CW-1:0] c;
    logic          to;
  } exp_t;

  exp_t         sb_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           prev_rise = 0;
  bit           prev_valid = 1'b0;
  bit           mon_on = 1'b0;
  logic [N-1:0] near_m = '0;
  logic         buzz_m = 1'b0;

  ultrasonic_ping_scheduler #(
    .N_SENSORS     (N),
    .TRIG_CYCLES   (TRIG_C),
    .SLOT_CYCLES   (SLOT_C),
    .TIMEOUT_CYCLES(TO_C),
    .CNT_W         (CW),
    .NEAR_THRESH   (THRESH)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .echo       (echo),
    .trig       (trig),
    .dist_valid (dist_valid),
    .dist_sensor(dist_sensor),
    .dist_count (dist_count),
    .timeout    (timeout),
    .near       (near),
    .buzz_en    (buzz_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected result of a slot whose raw echo is high for w cycles starting at
  // slot cycle k. The synchronizer delays it by 2, measurement can start no
  // earlier than the first WAIT_RISE cycle, and the slot times out at TO_LAST.
  function automatic exp_t model(input int s, input int k, input int w);
    exp_t m;
    int   r;
    int   e;
    m.s  = 2'(s);
    m.c  = '1;
    m.to = 1'b1;
    r = (k + 2 < TRIG_C) ? TRIG_C : k + 2;
    e = k + w + 2;
    if (w > 0 && r < TO_LAST && e <= TO_LAST - 1) begin
      m.to = 1'b0;
      m.c  = (e - r > 255) ? 8'hFF : 8'(e - r);
    end
    return m;
  endfunction

  task automatic wait_trig(input logic [N-1:0] oh, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 450 && !seen; i++) begin
      @(negedge clk);
      if (trig == oh) seen = 1'b1;
    end
    check_eq("trig_rise", 32'(seen), 1);
  endtask

  // Serve one slot of sensor s: raw echo pulse (k, w), optional echo noise on
  // the other sensors, optional en drop at slot cycle drop.
  task automatic run_slot(input int s, input int k, input int w, input bit noise,
                          input int drop);
    logic [N-1:0] oh;
    bit           seen;
    oh    = '0;
    oh[s] = 1'b1;
    wait_trig(oh, seen);
    if (!seen) return;
    if (prev_valid) check_eq("slot_period", cyc - prev_rise, SLOT_C);
    prev_rise  = cyc;
    prev_valid = 1'b1;
    sb_q.push_back(model(s, k, w));
    for (int c = 1; c < SLOT_C; c++) begin
      @(negedge clk);
      if (c <= TRIG_C) check_eq("trig_width", 32'(trig), (c < TRIG_C) ? 32'(oh) : 32'd0);
      for (int j = 0; j < N; j++) begin
        if (j == s) echo[j] = (w > 0 && c >= k && c < k + w);
        else        echo[j] = (noise && c >= 5 && c < 60);
      end
      if (c == drop) en = 1'b0;
    end
    echo = '0;
  endtask

  // Per-cycle monitor: one-hot trig, near/buzz model, scoreboard on dist_valid.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        check_eq("trig_onehot", 32'($countones(trig) <= 1), 1);
        check_eq("near", 32'(near), 32'(near_m));
        check_eq("buzz_en", 32'(buzz_en), 32'(buzz_m));
        buzz_m = |near_m;
        if (dist_valid) begin
          check_eq("result_expected", 32'(sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("dist_sensor", 32'(dist_sensor), 32'(e.s));
            check_eq("dist_count", 32'(dist_count), 32'(e.c));
            check_eq("timeout", 32'(timeout), 32'(e.to));
            near_m[e.s] = !e.to && (int'(e.c) < THRESH);
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_trig"}, 32'(trig), 0);
    check_eq({tag, "_dist_valid"}, 32'(dist_valid), 0);
    check_eq({tag, "_dist_sensor"}, 32'(dist_sensor), 0);
    check_eq({tag, "_dist_count"}, 32'(dist_count), 0);
    check_eq({tag, "_timeout"}, 32'(timeout), 0);
    check_eq({tag, "_near"}, 32'(near), 0);
    check_eq({tag, "_buzz_en"}, 32'(buzz_en), 0);
  endtask

  initial begin : stimulus
    int idle_trig;
    bit seen;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    en     = 1'b1;
    rst_n  = 1'b1;
    near_m = '0;
    buzz_m = 1'b0;
    mon_on = 1'b1;

    run_slot(0, 0, 0, 1'b1, -1);     // no echo: timeout, noise ignored
    run_slot(1, 14, 30, 1'b0, -1);   // near[1] set
    run_slot(2, 30, 49, 1'b1, -1);   // just below threshold
    run_slot(3, 1, 10, 1'b0, -1);    // echo already high when TRIG ends
    run_slot(0, 40, 50, 1'b0, -1);   // exactly at threshold: not near
    run_slot(1, 14, 100, 1'b0, -1);  // near[1] clears
    run_slot(2, 138, 50, 1'b0, -1);  // still high at timeout
    run_slot(3, 147, 20, 1'b1, -1);  // rise seen on the timeout cycle
    run_slot(0, 20, 126, 1'b0, -1);  // falls on the last cycle before timeout
    run_slot(1, 20, 127, 1'b0, -1);  // falls on the timeout cycle
    run_slot(2, 20, 40, 1'b0, 40);   // en dropped mid-measure

    idle_trig = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (trig != '0) idle_trig++;
    end
    check_eq("idle_no_trig", idle_trig, 0);

    en         = 1'b1;
    prev_valid = 1'b0;
    run_slot(3, 14, 10, 1'b0, -1);   // resumes at stored index

    wait_trig(4'b0001, seen);
    @(negedge clk);
    mon_on = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    check_all_zero("midtrig_reset");
    repeat (5) @(negedge clk);
    check_eq("trig_in_reset", 32'(trig), 0);

    near_m     = '0;
    buzz_m     = 1'b0;
    rst_n      = 1'b1;
    mon_on     = 1'b1;
    prev_valid = 1'b0;
    run_slot(0, 14, 20, 1'b0, -1);

    repeat (5) @(negedge clk);
    check_eq("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ultrasonic_ping_scheduler.md
Name: ultrasonic_ping_scheduler

Overview:
Time-multiplexes one ping/measure engine across N ultrasonic rangefinders (front/rear/left/right on the rover). Sensors are served round-robin, one per fixed-length slot, so their echoes never cross-talk. Each sensor in turn gets a trigger pulse, and the block then measures its echo pulse width in clock cycles, with a timeout. It publishes each result with a one-cycle valid strobe and holds a per-sensor "near" flag that drives the buzzer/LED logic downstream.

Parameters:
N_SENSORS, 4, number of sensors served (2..8); index width IDX_W = clog2(N_SENSORS)
TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz)
SLOT_CYCLES, 3000000, total cycles per sensor slot (60 ms); must exceed TIMEOUT_CYCLES+2
TIMEOUT_CYCLES, 1500000, max cycles from slot start before the measurement is abandoned
CNT_W, 23, width of the echo width counter
NEAR_THRESH, 29000, echo count strictly below this sets the sensor's near flag

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
en  in  1  scheduler enable
echo  in  N_SENSORS  raw echo lines from the sensors, asynchronous
trig  out  N_SENSORS  trigger lines; at most one bit high at any time
dist_valid  out  1  one-cycle strobe: new result on dist_sensor/dist_count/timeout
dist_sensor  out  IDX_W  index of the sensor the result belongs to
dist_count  out  CNT_W  echo high time in cycles; all-ones on timeout
timeout  out  1  qualifies dist_valid: the slot timed out
near  out  N_SENSORS  per-sensor proximity flags
buzz_en  out  1  OR of near

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM=IDLE, sensor index=0, slot_cnt=0.
  - trig=0, dist_valid=0, dist_sensor=0, dist_count=0, timeout=0, near=0, buzz_en=0.
  - Synchronizer flops are cleared.
  - Reset mid-slot aborts the slot; no result is produced.
- Echo input: each bit passes through a 2-FF synchronizer, giving 2 cycles of latency. The FSM looks only at the synchronized bit of the current sensor; the other echo bits are ignored.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, HOLDOFF.
  - IDLE: if en=1, go to TRIG next cycle and set slot_cnt=0.
  - TRIG: trig[idx]=1, registered, for exactly TRIG_CYCLES cycles; then go to WAIT_RISE.
  - WAIT_RISE: when synchronized echo=1, go to MEASURE and set echo counter=1.
  - MEASURE: the echo counter increments each cycle echo stays 1. It saturates at all-ones and does not wrap. On echo=0, go to REPORT with timeout=0.
  - REPORT: lasts one cycle. dist_valid=1, dist_sensor=idx, dist_count=final counter value, timeout flag set as determined. Then go to HOLDOFF.
  - HOLDOFF: wait until slot_cnt == SLOT_CYCLES-1. Then idx = (idx+1) mod N_SENSORS, wrapping from N_SENSORS-1 to 0. Go to TRIG with slot_cnt=0; if en=0, go to IDLE instead.
- Slot counter: slot_cnt increments every cycle outside IDLE and resets to 0 at each slot start. The slot period is therefore exactly SLOT_CYCLES, regardless of echo length.
- Timeout:
  - Applies in WAIT_RISE or MEASURE when slot_cnt reaches TIMEOUT_CYCLES-1. Go to REPORT with timeout=1 and dist_count=all-ones.
  - Timeout has priority over a simultaneous echo edge.
- Measured width equals the synchronized echo high time in cycles. An echo already high when TRIG ends is measured from the WAIT_RISE entry.
- dist_count, dist_sensor and timeout hold their values between strobes.
- near[idx] is updated in the REPORT cycle (visible the cycle after dist_valid):
  - set to 1 if timeout=0 and dist_count < NEAR_THRESH;
  - cleared otherwise, including on timeout.
  - Other near bits are unchanged.
  - buzz_en = |near, registered, so it lags near by one cycle.
- en deasserted mid-slot: the current slot runs to completion (result reported, full holdoff), then the FSM goes to IDLE. idx has already advanced. near flags hold their values in IDLE.
- en reasserted: the next slot starts with the stored idx.

Test Plan:
Bench parameters: N_SENSORS=4, TRIG_CYCLES=4, SLOT_CYCLES=200, TIMEOUT_CYCLES=150, NEAR_THRESH=50, CNT_W=8.
1. Reset then en=1, no echo -> trig[0] high for exactly cycles 1..4. dist_valid with dist_sensor=0, timeout=1, dist_count=255. Next trig is trig[1], exactly 200 cycles after trig[0] rose. near=0.
2. Sensor 1 echo high for 30 cycles starting 10 cycles after trig falls -> dist_valid, dist_sensor=1, dist_count=30, timeout=0. near=4'b0010 one cycle later; buzz_en=1 one cycle after that.
3. Sensor 1 next serviced with a 100-cycle echo -> dist_count=100, near[1] clears, buzz_en returns to 0.
4. Round-robin wrap: run 5 slots -> dist_sensor sequence 0,1,2,3,0. trig never has two bits high at once. Echo pulses on non-selected sensors produce no effect.
5. Echo rises at slot_cnt=140 and stays high -> timeout at slot_cnt=149: dist_count=255, timeout=1, near bit cleared.
6. en dropped mid-MEASURE of sensor 2 -> result still reported, FSM idles after holdoff. rst_n=0 pulsed mid-TRIG -> trig=0 and all outputs 0 the next cycle; after release, resumes at sensor 0.
